// File: rtl/autobaud_pkg.sv
// Shared types and constants for the autobaud detector.
// The 0x55 calibration character gives 5 falling edges spanning 8 bit-times.
`timescale 1ns/1ps
package autobaud_pkg;

    typedef enum logic [2:0] {
        IDLE_WAIT,
        ARMED,
        MEASURE,
        DONE,
        LOCKED
    } state_t;

    localparam int EDGES_PER_CAL = 5;
    localparam int BITS_PER_CAL  = 8;
    localparam int DIV_SHIFT     = $clog2(BITS_PER_CAL);
    localparam int ROUND_ADD     = BITS_PER_CAL / 2;
    localparam int TOL_SHIFT     = 3;

endpackage

// File: rtl/autobaud_detector_rx_sync.sv
// Two-flop synchroniser for the raw rx line plus a registered previous
// sample, producing a one-cycle falling-edge strobe. Resets to idle-high.
`timescale 1ns/1ps
module rx_sync_edge (
    input  logic clkin,
    input  logic rst,
    input  logic rx,
    output logic sync_cur,
    output logic fall
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;

    always_comb begin
        sync1_d = rx;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign sync_cur = sync2_q;
    assign fall     = prev_q & ~sync2_q;

endmodule

// File: rtl/autobaud_detector.sv
// Measures the UART bit period from a 0x55 calibration character and
// publishes baud_div = round(span/8). Define AUTOBAUD_CHECK_EN to also
// reject characters whose edge-to-edge intervals are inconsistent.
`timescale 1ns/1ps
module autobaud_detector
    import autobaud_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int CNT_W    = 24,
    parameter int IDLE_MIN = 64,
    parameter int MIN_DIV  = 16
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             rx,
    input  logic             rearm,
    output logic [CNT_W-4:0] baud_div,
    output logic             baud_valid,
    output logic             locked,
    output logic             err
);

    localparam int DIV_W  = CNT_W - DIV_SHIFT;
    localparam int IDLE_W = $clog2(IDLE_MIN + 1);

    if (CLK_FREQ < 1 || CNT_W < 8 || IDLE_MIN < 1 || MIN_DIV < 1) begin : g_bad_params
        $error("autobaud_detector: invalid parameter set");
    end

    logic sync_cur;
    logic fall;

    rx_sync_edge u_sync (
        .clkin    (clkin),
        .rst      (rst),
        .rx       (rx),
        .sync_cur (sync_cur),
        .fall     (fall)
    );

    state_t             state_q, state_d;
    logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic [CNT_W-1:0]   meas_cnt_q, meas_cnt_d;
    logic [2:0]         edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DIV_W-1:0]   baud_div_q, baud_div_d;
    logic               baud_valid_q, baud_valid_d;
    logic               locked_q, locked_d;
    logic               err_q, err_d;

    logic [CNT_W-1:0]   stamp;
    logic [DIV_W-1:0]   div;
    logic               interval_bad;

    // stamp is the edge-1-relative cycle count of a fall seen this cycle
    assign stamp = meas_cnt_q + CNT_W'(1);
    assign div   = DIV_W'((count_q + CNT_W'(ROUND_ADD)) >> DIV_SHIFT);

`ifdef AUTOBAUD_CHECK_EN
    logic [CNT_W-1:0] ref_int_q, ref_int_d;
    logic [CNT_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] interval;
    logic [CNT_W-1:0] deviation;

    // The edge 1->2 interval is the reference; later intervals must match it
    always_comb begin
        ref_int_d    = ref_int_q;
        last_d       = last_q;
        interval     = stamp - last_q;
        deviation    = (interval >= ref_int_q) ? (interval - ref_int_q)
                                               : (ref_int_q - interval);
        interval_bad = 1'b0;
        if (state_q == ARMED) begin
            last_d = '0;
        end else if (state_q == MEASURE && fall) begin
            last_d = stamp;
            if (edge_cnt_q == 3'd1) begin
                ref_int_d = interval;
            end else begin
                interval_bad = deviation > (ref_int_q >> TOL_SHIFT);
            end
        end
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            ref_int_q <= '0;
            last_q    <= '0;
        end else begin
            ref_int_q <= ref_int_d;
            last_q    <= last_d;
        end
    end
`else
    assign interval_bad = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        idle_cnt_d   = idle_cnt_q;
        meas_cnt_d   = meas_cnt_q;
        edge_cnt_d   = edge_cnt_q;
        count_d      = count_q;
        baud_div_d   = baud_div_q;
        baud_valid_d = 1'b0;
        locked_d     = locked_q;
        err_d        = 1'b0;

        if (rearm) begin
            state_d    = IDLE_WAIT;
            idle_cnt_d = '0;
            locked_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE_WAIT: begin
                    if (!sync_cur) begin
                        idle_cnt_d = '0;
                    end else if (idle_cnt_q == IDLE_W'(IDLE_MIN - 1)) begin
                        idle_cnt_d = '0;
                        state_d    = ARMED;
                    end else begin
                        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                    end
                end
                ARMED: begin
                    if (fall) begin
                        meas_cnt_d = '0;
                        edge_cnt_d = 3'd1;
                        state_d    = MEASURE;
                    end
                end
                MEASURE: begin
                    if (meas_cnt_q != '1) begin
                        meas_cnt_d = stamp;
                    end
                    // A final edge beats a simultaneous timeout
                    if (fall && interval_bad) begin
                        err_d   = 1'b1;
                        state_d = IDLE_WAIT;
                    end else if (fall && edge_cnt_q == 3'(EDGES_PER_CAL - 1)) begin
                        count_d = stamp;
                        state_d = DONE;
                    end else if (meas_cnt_q == '1) begin
                        err_d   = 1'b1;
                        state_d = IDLE_WAIT;
                    end else if (fall) begin
                        edge_cnt_d = edge_cnt_q + 3'd1;
                    end
                end
                DONE: begin
                    if (div >= DIV_W'(MIN_DIV)) begin
                        baud_div_d   = div;
                        baud_valid_d = 1'b1;
                        locked_d     = 1'b1;
                        state_d      = LOCKED;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE_WAIT;
                    end
                end
                LOCKED: begin
                    state_d = LOCKED;
                end
                default: begin
                    state_d = IDLE_WAIT;
                end
            endcase
        end
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE_WAIT;
            idle_cnt_q   <= '0;
            meas_cnt_q   <= '0;
            edge_cnt_q   <= '0;
            count_q      <= '0;
            baud_div_q   <= '0;
            baud_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            idle_cnt_q   <= idle_cnt_d;
            meas_cnt_q   <= meas_cnt_d;
            edge_cnt_q   <= edge_cnt_d;
            count_q      <= count_d;
            baud_div_q   <= baud_div_d;
            baud_valid_q <= baud_valid_d;
            locked_q     <= locked_d;
            err_q        <= err_d;
        end
    end

    assign baud_div   = baud_div_q;
    assign baud_valid = baud_valid_q;
    assign locked     = locked_q;
    assign err        = err_q;

endmodule

// File: tb/tb_autobaud_detector.sv
// Scoreboard bench for autobaud_detector: a default-sized instance for the
// calibration scenarios and a CNT_W=12 instance for the measurement timeout.
`timescale 1ns/1ps
module tb_autobaud_detector;

    typedef struct {
        bit is_err;
        int div;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx = 1'b1;
    logic        rearm = 1'b0;
    logic [20:0] baud_div;
    logic        baud_valid, locked, err;

    logic        rx_b = 1'b1;
    logic [8:0]  baud_div_b;
    logic        baud_valid_b, locked_b, err_b;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t expq[$];
    int   expq_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    autobaud_detector dut (
        .clkin      (clk),
        .rst        (rst),
        .rx         (rx),
        .rearm      (rearm),
        .baud_div   (baud_div),
        .baud_valid (baud_valid),
        .locked     (locked),
        .err        (err)
    );

    autobaud_detector #(.CNT_W(12)) dut_b (
        .clkin      (clk),
        .rst        (rst),
        .rx         (rx_b),
        .rearm      (1'b0),
        .baud_div   (baud_div_b),
        .baud_valid (baud_valid_b),
        .locked     (locked_b),
        .err        (err_b)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Main-instance monitor: every baud_valid/err pulse must match the queue head
    always @(negedge clk) begin
        if (!rst && (baud_valid || err)) begin
            exp_t e;
            checks++;
            if (baud_valid && err) begin
                failures++;
                $display("[TB] FAIL pulse_overlap: got valid=1 err=1 expected one of them");
            end else if (expq.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_pulse: got valid=%0d err=%0d div=%0d expected none",
                         baud_valid, err, baud_div);
            end else begin
                e = expq.pop_front();
                if (err != e.is_err || int'(baud_div) != e.div) begin
                    failures++;
                    $display("[TB] FAIL event: got err=%0d div=%0d expected err=%0d div=%0d",
                             err, baud_div, e.is_err, e.div);
                end
            end
        end
    end

    // Timeout-instance monitor: queue holds the cycle rx_b went low
    always @(negedge clk) begin
        if (!rst && (baud_valid_b || err_b)) begin
            int c0;
            checks++;
            if (expq_b.size() == 0 || baud_valid_b) begin
                failures++;
                $display("[TB] FAIL timeout_unexpected: got valid=%0d err=%0d expected none",
                         baud_valid_b, err_b);
            end else begin
                c0 = expq_b.pop_front();
                if (cyc - c0 < 4096 || cyc - c0 > 4102) begin
                    failures++;
                    $display("[TB] FAIL timeout_delay: got %0d cycles expected 4096..4102",
                             cyc - c0);
                end
            end
        end
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends the first nbits of a 0x55 frame; stretch_bit lasts 1.5 periods
    task automatic applyStimulus(input real period, input int nbits, input int stretch_bit);
        logic [9:0] frame;
        real t;
        int  prev_e;
        int  cur_e;
        frame  = {1'b1, 8'h55, 1'b0};
        t      = 0.0;
        prev_e = 0;
        for (int i = 0; i < nbits; i++) begin
            t     = t + ((i == stretch_bit) ? period * 1.5 : period);
            cur_e = $rtoi(t + 0.5);
            rx    = frame[i];
            repeat (cur_e - prev_e) @(posedge clk);
            #1;
            prev_e = cur_e;
        end
        rx = 1'b1;
    endtask

    task automatic pulseRearm();
        rearm = 1'b1;
        @(posedge clk);
        #1;
        rearm = 1'b0;
    endtask

    task automatic expectEvent(input bit is_err, input int div);
        exp_t e;
        e.is_err = is_err;
        e.div    = div;
        expq.push_back(e);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_baud_div", int'(baud_div), 0);
        checkOutput("reset_valid", int'(baud_valid), 0);
        checkOutput("reset_locked", int'(locked), 0);
        checkOutput("reset_err", int'(err), 0);
        rst = 1'b0;

        // Timeout on the CNT_W=12 instance: rx stuck low after the first fall
        idle(100);
        expq_b.push_back(cyc);
        rx_b = 1'b0;
        repeat (4200) @(posedge clk);
        #1;
        rx_b = 1'b1;
        checkOutput("timeout_pending", expq_b.size(), 0);
        checkOutput("timeout_locked", int'(locked_b), 0);

        // 115200 baud at 100 MHz
        expectEvent(1'b0, 868);
        applyStimulus(868.0, 10, -1);
        idle(20);
        checkOutput("lock868_pending", expq.size(), 0);
        checkOutput("lock868_locked", int'(locked), 1);
        checkOutput("lock868_div", int'(baud_div), 868);

        // Further characters are ignored while locked
        applyStimulus(434.0, 10, -1);
        idle(20);
        checkOutput("locked_hold_div", int'(baud_div), 868);
        checkOutput("locked_hold_locked", int'(locked), 1);

        pulseRearm();
        checkOutput("rearm_locked_drop", int'(locked), 0);
        idle(100);
        expectEvent(1'b0, 434);
        applyStimulus(434.0, 10, -1);
        idle(20);
        checkOutput("lock434_pending", expq.size(), 0);
        checkOutput("lock434_locked", int'(locked), 1);

        // 10 cycles/bit gives div 10, below MIN_DIV; prior divisor is kept
        pulseRearm();
        idle(100);
        expectEvent(1'b1, 434);
        applyStimulus(10.0, 10, -1);
        idle(20);
        checkOutput("small_div_pending", expq.size(), 0);
        checkOutput("small_div_locked", int'(locked), 0);

        // Jittered edges: span 6955 cycles rounds to 869
        idle(100);
        expectEvent(1'b0, 869);
        applyStimulus(869.4, 10, -1);
        idle(20);
        checkOutput("jitter_pending", expq.size(), 0);
        checkOutput("jitter_div", int'(baud_div), 869);

        // Asynchronous reset after two falling edges
        pulseRearm();
        idle(100);
        applyStimulus(868.0, 4, -1);
        rst = 1'b1;
        #1;
        checkOutput("midrst_div", int'(baud_div), 0);
        checkOutput("midrst_locked", int'(locked), 0);
        checkOutput("midrst_valid", int'(baud_valid), 0);
        checkOutput("midrst_err", int'(err), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(100);
        expectEvent(1'b0, 868);
        applyStimulus(868.0, 10, -1);
        idle(20);
        checkOutput("relock_pending", expq.size(), 0);
        checkOutput("relock_locked", int'(locked), 1);

`ifdef AUTOBAUD_CHECK_EN
        // Edge 2->3 interval stretched by 25% must be rejected
        pulseRearm();
        idle(100);
        expectEvent(1'b1, 868);
        applyStimulus(868.0, 10, 3);
        idle(20);
        checkOutput("stretch_pending", expq.size(), 0);
        checkOutput("stretch_locked", int'(locked), 0);
`endif

        checkOutput("final_timeout_pending", expq_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
